change_dispenser: RTL

//  Payout end of the vending machine. Accepts one vend result per transaction:
//  - a product code
//  - a 4-bit balance
//  It strobes the product release, then pays the balance out as coins to the

---
 rtl/vm_pkg.sv | 23 ++
 rtl/coin_select.sv | 28 ++
 rtl/change_dispenser.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// Shared coin codes and payout FSM state encoding for the vending machine payout path.
package vm_pkg;

   localparam logic [2:0] COIN_NONE = 3'd0;
   localparam logic [2:0] COIN_1    = 3'd1;
   localparam logic [2:0] COIN_2    = 3'd2;
   localparam logic [2:0] COIN_5    = 3'd5;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PROD  = 3'd1;
   localparam logic [2:0] ST_PAY   = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_FAULT = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_PROD  = ST_PROD,
      S_PAY   = ST_PAY,
      S_DONE  = ST_DONE,
      S_FAULT = ST_FAULT
   } state_e;

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest available denomination not exceeding the amount still owed.
module coin_select
   import vm_pkg::*;
#(
   parameter int BAL_W  = 4,
   parameter int COIN_W = 3
) (
   input  logic [BAL_W-1:0]  rem_i,
   input  logic              avail5_i,
   input  logic              avail2_i,
   input  logic              avail1_i,
   output logic [COIN_W-1:0] coin_o,
   output logic              none_o
);

   always_comb begin
      coin_o = COIN_W'(COIN_NONE);
      if (avail5_i && (rem_i >= BAL_W'(COIN_5))) begin
         coin_o = COIN_W'(COIN_5);
      end else if (avail2_i && (rem_i >= BAL_W'(COIN_2))) begin
         coin_o = COIN_W'(COIN_2);
      end else if (avail1_i && (rem_i != '0)) begin
         coin_o = COIN_W'(COIN_1);
      end
      none_o = (coin_o == COIN_W'(COIN_NONE));
   end

endmodule

// File: rtl/change_dispenser.sv
// Payout end of the vending machine: product release strobe, then change paid coin by coin.
// Optional per-denomination stock tracking is enabled by defining CHANGE_DISPENSER_INVENTORY_EN.
module change_dispenser
   import vm_pkg::*;
#(
   parameter int BAL_W      = 4,
   parameter int COIN_W     = 3,
   parameter int ACK_TMO    = 15,
   parameter int STOCK_W    = 6,
   parameter int STOCK_INIT = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vend_valid,
   input  logic [1:0]        prod,
   input  logic [BAL_W-1:0]  bal,
   output logic              ready,
   output logic [1:0]        prod_out,
   output logic              prod_strobe,
   output logic [COIN_W-1:0] coin_val,
   output logic              coin_valid,
   input  logic              coin_ack,
   output logic              done,
   output logic              short_flag,
   output logic              fault
);

   localparam int TMO_W = $clog2(ACK_TMO + 1);

   if (STOCK_INIT >= (2 ** STOCK_W)) begin : g_stock_range
      $error("STOCK_INIT does not fit in STOCK_W bits");
   end

   state_e             state_q, state_d;
   logic [BAL_W-1:0]   rem_q, rem_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [1:0]         prod_q, prod_d;
   logic [COIN_W-1:0]  sel_coin;
   logic               sel_none;
   logic [2:0]         avail;
   logic               ack_take;
   logic               short_en;

   coin_select #(
      .BAL_W  (BAL_W),
      .COIN_W (COIN_W)
   ) u_coin_select (
      .rem_i    (rem_q),
      .avail5_i (avail[2]),
      .avail2_i (avail[1]),
      .avail1_i (avail[0]),
      .coin_o   (sel_coin),
      .none_o   (sel_none)
   );

`ifdef CHANGE_DISPENSER_INVENTORY_EN
   logic [STOCK_W-1:0] stk5_q, stk2_q, stk1_q;
   logic [STOCK_W-1:0] stk5_d, stk2_d, stk1_d;

   function automatic logic [STOCK_W-1:0] sat_dec(input logic [STOCK_W-1:0] v);
      return (v == '0) ? v : v - STOCK_W'(1);
   endfunction

   always_comb begin
      stk5_d = stk5_q;
      stk2_d = stk2_q;
      stk1_d = stk1_q;
      if (ack_take) begin
         if (sel_coin == COIN_W'(COIN_5))      stk5_d = sat_dec(stk5_q);
         else if (sel_coin == COIN_W'(COIN_2)) stk2_d = sat_dec(stk2_q);
         else if (sel_coin == COIN_W'(COIN_1)) stk1_d = sat_dec(stk1_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stk5_q <= STOCK_W'(STOCK_INIT);
         stk2_q <= STOCK_W'(STOCK_INIT);
         stk1_q <= STOCK_W'(STOCK_INIT);
      end else begin
         stk5_q <= stk5_d;
         stk2_q <= stk2_d;
         stk1_q <= stk1_d;
      end
   end

   assign avail    = {stk5_q != '0, stk2_q != '0, stk1_q != '0};
   assign short_en = 1'b1;
`else
   assign avail    = 3'b111;
   assign short_en = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      tmo_d       = tmo_q;
      prod_d      = prod_q;
      ready       = 1'b0;
      prod_strobe = 1'b0;
      coin_valid  = 1'b0;
      coin_val    = COIN_W'(COIN_NONE);
      done        = 1'b0;
      short_flag  = 1'b0;
      fault       = 1'b0;
      ack_take    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            ready = 1'b1;
            if (vend_valid) begin
               prod_d  = prod;
               rem_d   = bal;
               state_d = S_PROD;
            end
         end
         S_PROD: begin
            prod_strobe = (prod_q != 2'd0);
            tmo_d       = '0;
            state_d     = sel_none ? S_DONE : S_PAY;
         end
         S_PAY: begin
            // Nothing payable left with money still owed: only reachable when stock runs dry.
            if (sel_none) begin
               state_d = S_DONE;
            end else begin
               coin_valid = 1'b1;
               coin_val   = sel_coin;
               if (coin_ack) begin
                  ack_take = 1'b1;
                  rem_d    = rem_q - BAL_W'(sel_coin);
                  tmo_d    = '0;
                  if (rem_d == '0) state_d = S_DONE;
               end else if (tmo_q == TMO_W'(ACK_TMO - 1)) begin
                  state_d = S_FAULT;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
            end
         end
         S_DONE: begin
            done       = 1'b1;
            short_flag = short_en && (rem_q != '0);
            state_d    = S_IDLE;
         end
         S_FAULT: begin
            fault = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         tmo_q   <= '0;
         prod_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         tmo_q   <= tmo_d;
         prod_q  <= prod_d;
      end
   end

   assign prod_out = prod_q;

endmodule
